fft_controller: RTL and testbench

- Sequences the radix-2 butterfly datapath through a full in-place N-point FFT (decimation-in-time, input stored bit-reversed).
- Issues, every cycle, the A/B read addresses and the twiddle-ROM address for one butterfly.
- Delays those addresses to match the datapath latency, then issues the A'/B' write-back.
- Inserts a drain gap between stages so that no read overtakes a pending write. Sits between the system start/done handshake and the data RAM, twiddle ROM and butterfly.

---
 rtl/fft_controller.sv | 145 ++++++++++++++
 tb/tb_fft_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fft_controller.sv
// In-place radix-2 DIT FFT address sequencer: it issues one butterfly per cycle and
// delays the read addresses by the datapath latency to form the write-back.
module fft_controller #(
  parameter int LOG2_N   = 5,
  parameter int BFLY_LAT = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic [LOG2_N-1:0]           rd_addr_a_o,
  output logic [LOG2_N-1:0]           rd_addr_b_o,
  output logic [LOG2_N-2:0]           tw_addr_o,
  output logic [LOG2_N-1:0]           wr_addr_a_o,
  output logic [LOG2_N-1:0]           wr_addr_b_o,
  output logic                        wr_en_o,
  output logic [$clog2(LOG2_N)-1:0]   stage_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int IW = LOG2_N - 1;
  localparam int SW = $clog2(LOG2_N);
  localparam int DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(BFLY_LAT - 1);
  localparam logic [SW-1:0] S_LAST     = SW'(LOG2_N - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_e;

  state_e          state_q;
  logic [SW-1:0]   s_q;
  logic [IW-1:0]   i_q;
  logic [DW-1:0]   dcnt_q;
  logic            busy_q;
  logic            done_q;

  logic            issue_d;
  logic [LOG2_N-1:0] rd_a_d;
  logic [LOG2_N-1:0] rd_b_d;
  logic [IW-1:0]   tw_mask_d;
  logic [IW-1:0]   tw_d;

  logic [LOG2_N-1:0] pa_q [BFLY_LAT];
  logic [LOG2_N-1:0] pb_q [BFLY_LAT];
  logic              pv_q [BFLY_LAT];

  function automatic logic [LOG2_N-1:0] rotl(input logic [LOG2_N-1:0] x,
                                             input logic [SW-1:0] sh);
    return (x << sh) | (x >> (LOG2_N - int'(sh)));
  endfunction

  always_comb begin
    issue_d   = (state_q == COMPUTE);
    rd_a_d    = '0;
    rd_b_d    = '0;
    tw_d      = '0;
    tw_mask_d = {IW{1'b1}} << (S_LAST - s_q);
    if (issue_d) begin
      rd_a_d = rotl({i_q, 1'b0}, s_q);
      rd_b_d = rotl({i_q, 1'b1}, s_q);
      tw_d   = i_q & tw_mask_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      s_q     <= '0;
      i_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= COMPUTE;
            s_q     <= '0;
            i_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        COMPUTE: begin
          if (i_q == {IW{1'b1}}) begin
            state_q <= DRAIN;
            i_q     <= '0;
            dcnt_q  <= DRAIN_LOAD;
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        DRAIN: begin
          // The pipe is empty once the drain count expires, so the stage can advance safely.
          if (dcnt_q == '0) begin
            if (s_q == S_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              s_q     <= s_q + SW'(1);
              state_q <= COMPUTE;
            end
          end else begin
            dcnt_q <= dcnt_q - DW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          s_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < BFLY_LAT; k++) begin
        pa_q[k] <= '0;
        pb_q[k] <= '0;
        pv_q[k] <= 1'b0;
      end
    end else begin
      pa_q[0] <= rd_a_d;
      pb_q[0] <= rd_b_d;
      pv_q[0] <= issue_d;
      for (int k = 1; k < BFLY_LAT; k++) begin
        pa_q[k] <= pa_q[k-1];
        pb_q[k] <= pb_q[k-1];
        pv_q[k] <= pv_q[k-1];
      end
    end
  end

  assign rd_addr_a_o = rd_a_d;
  assign rd_addr_b_o = rd_b_d;
  assign tw_addr_o   = tw_d;
  assign wr_addr_a_o = pa_q[BFLY_LAT-1];
  assign wr_addr_b_o = pb_q[BFLY_LAT-1];
  assign wr_en_o     = pv_q[BFLY_LAT-1];
  assign stage_o     = s_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_fft_controller.sv
// Scoreboard bench for fft_controller (LOG2_N=5, BFLY_LAT=1): expected write-backs are
// queued at issue time and popped when wr_en appears.
module tb_fft_controller;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [4:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
  logic [3:0] tw_addr_o;
  logic       wr_en_o, busy_o, done_o;
  logic [2:0] stage_o;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb[$];

  fft_controller #(.LOG2_N(5), .BFLY_LAT(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .tw_addr_o(tw_addr_o),
    .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o), .wr_en_o(wr_en_o),
    .stage_o(stage_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rotl_m(input int x, input int s);
    int r = 0;
    for (int k = 0; k < 5; k++)
      if (x[k]) r |= 1 << ((k + s) % 5);
    return r;
  endfunction

  function automatic logic [31:0] all_outs();
    return {2'b0, rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o,
            wr_en_o, stage_o, busy_o, done_o};
  endfunction

  // Starts a run from IDLE at a negedge; returns at the done negedge (or after an abort).
  task automatic run_fft(input int restart_at, input int abort_at);
    int busy_n = 0, wr_n = 0, gap_n = 0, done_n = 0;
    int hits[5][32];
    logic [9:0] w;
    for (int a = 0; a < 5; a++) for (int b = 0; b < 32; b++) hits[a][b] = 0;
    sb.delete();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int t = 0; t <= 85; t++) begin
      int s   = t / 17;
      int idx = t % 17;
      bit iss  = (t < 85) && (idx < 16);
      bit piss = (t >= 1) && (((t - 1) % 17) < 16) && (t - 1 < 85);
      chk("busy", busy_o, t < 85);
      chk("done", done_o, t == 85);
      chk("wr_en", wr_en_o, piss);
      if (t < 85) chk("stage", stage_o, s);
      if (iss) begin
        chk("rd_a", rd_addr_a_o, rotl_m(2 * idx, s));
        chk("rd_b", rd_addr_b_o, rotl_m(2 * idx + 1, s));
        chk("tw", tw_addr_o, (idx >> (4 - s)) << (4 - s));
      end else begin
        chk("rd_idle", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, 0);
      end
      if (t == 0)  chk("s0_i0", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, {5'd0, 5'd1, 4'd0});
      if (t == 3)  chk("s0_i3", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, {5'd6, 5'd7, 4'd0});
      if (t == 1)  chk("first_wr", {wr_en_o, wr_addr_a_o, wr_addr_b_o}, {1'b1, 5'd0, 5'd1});
      if (t == 17) chk("s1_i0", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, {5'd0, 5'd2, 4'd0});
      if (t == 18) chk("s1_i1", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, {5'd4, 5'd6, 4'd0});
      if (t == 25) chk("s1_i8", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, {5'd1, 5'd3, 4'd8});
      if (t == 32) chk("s1_i15", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, {5'd29, 5'd31, 4'd8});
      if (t == 77) chk("s4_tw", tw_addr_o, 9);
      busy_n += busy_o;
      done_n += done_o;
      if (wr_en_o) begin
        wr_n++;
        if (sb.size() == 0) chk("sb_empty", 0, 1);
        else begin
          w = sb.pop_front();
          chk("wr_addr", {wr_addr_a_o, wr_addr_b_o}, w);
          if (t >= 1) begin
            hits[(t - 1) / 17][wr_addr_a_o]++;
            hits[(t - 1) / 17][wr_addr_b_o]++;
          end
        end
      end else if (t >= 1 && t <= 84) gap_n++;
      if (iss) sb.push_back({5'(rotl_m(2 * idx, s)), 5'(rotl_m(2 * idx + 1, s))});
      if (t == abort_at) begin
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        chk("abort_outs", all_outs(), 0);
        sb.delete();
        for (int c = 0; c < 30; c++) begin
          @(negedge clk_i);
          chk("abort_quiet", {wr_en_o, busy_o, done_o}, 0);
        end
        return;
      end
      start_i = (t == restart_at);
      if (t < 85) @(negedge clk_i);
    end
    start_i = 1'b0;
    chk("busy_cycles", busy_n, 85);
    chk("wr_cycles", wr_n, 80);
    chk("gap_cycles", gap_n, 4);
    chk("done_count", done_n, 1);
    chk("sb_left", sb.size(), 0);
    for (int a = 0; a < 5; a++) begin
      bit once = 1'b1;
      for (int b = 0; b < 32; b++) if (hits[a][b] != 1) once = 1'b0;
      chk("stage_cover", once, 1);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_held", all_outs(), 0);
    reset_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      chk("rst_idle", all_outs(), 0);
    end

    run_fft(-1, -1);
    @(negedge clk_i);
    run_fft(-1, -1);

    // start while in DONE must be dropped
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("done_start_ign", busy_o, 0);
    @(negedge clk_i);
    chk("done_start_ign2", busy_o, 0);

    run_fft(10, -1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("no_extra_done", {busy_o, done_o}, 0);
    end

    run_fft(-1, 40);
    run_fft(-1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
